// File: rtl/mips_div_unit_pkg.sv
// Shared constants and types for the DIV/DIVU unit: FSM encoding, handshake levels, bus widths.
package mips_div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam int          DoubleRegBus = 64;

    // Sign handling decided at acceptance; the magnitudes are divided unsigned.
    typedef struct packed {
        logic neg_quot;
        logic neg_rem;
    } div_fix_t;

endpackage

// File: rtl/mips_div_unit_step.sv
// One restoring-division iteration: shift the working register, trial-subtract, select.
module mips_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0] work_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [2*DATA_W:0] work_o
);

    logic [2*DATA_W:0] shifted;
    logic [DATA_W:0]   trial;

    assign shifted = {work_i[2*DATA_W-1:0], 1'b0};
    assign trial   = shifted[2*DATA_W:DATA_W] - {1'b0, divisor_i};

    // Partial remainder is always below the divisor, so trial MSB is a clean borrow flag.
    always_comb begin
        if (!trial[DATA_W])
            work_o = {trial, shifted[DATA_W-1:1], 1'b1};
        else
            work_o = shifted;
    end

endmodule

// File: rtl/mips_div_unit.sv
// Multi-cycle DIV/DIVU unit for the execute stage; result_o = {HI=remainder, LO=quotient}.
module mips_div_unit
    import mips_div_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W:0]   work_q, work_d, work_step;
    logic [DATA_W-1:0]   dvsr_q, dvsr_d;
    div_fix_t            fix_q, fix_d;
    logic [2*DATA_W-1:0] result_d;
    logic                ready_d;

    logic [DATA_W-1:0]   mag1, mag2, quot, rem, quot_fix, rem_fix;

    assign mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    assign quot     = work_q[DATA_W-1:0];
    assign rem      = work_q[2*DATA_W-1:DATA_W];
    assign quot_fix = fix_q.neg_quot ? -quot : quot;
    assign rem_fix  = fix_q.neg_rem  ? -rem  : rem;

    mips_div_step #(.DATA_W(DATA_W)) u_step (
        .work_i    (work_q),
        .divisor_i (dvsr_q),
        .work_o    (work_step)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dvsr_d   = dvsr_q;
        fix_d    = fix_q;
        result_d = result_o;
        ready_d  = ready_o;
        case (state_q)
            DivFree: begin
                ready_d  = DivResultNotReady;
                result_d = '0;
                if (start_i == DivStart && !annul_i) begin
                    fix_d.neg_quot = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    fix_d.neg_rem  = signed_div_i & opdata1_i[DATA_W-1];
                    dvsr_d         = mag2;
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d = DivOn;
                        cnt_d   = '0;
                        work_d  = {{(DATA_W+1){1'b0}}, mag1};
                    end
                end
            end
            DivByZero: begin
                state_d  = DivEnd;
                result_d = '0;
                ready_d  = DivResultReady;
            end
            DivOn: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    work_d = work_step;
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    state_d  = DivEnd;
                    result_d = {rem_fix, quot_fix};
                    ready_d  = DivResultReady;
                end
            end
            DivEnd: begin
                ready_d = DivResultReady;
                if (start_i == DivStop) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            work_q   <= '0;
            dvsr_q   <= '0;
            fix_q    <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            dvsr_q   <= dvsr_d;
            fix_q    <= fix_d;
            result_o <= result_d;
            ready_o  <= ready_d;
        end
    end

endmodule

// File: tb/tb_mips_div_unit.sv
// Self-checking bench for mips_div_unit against an arithmetic DIV/DIVU reference model.
module tb_mips_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        start_i, annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;

    mips_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // {HI=remainder, LO=quotient}; truncating division, remainder follows dividend sign.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] q32, r32;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        q32 = q[31:0];
        r32 = r[31:0];
        return {r32, q32};
    endfunction

    // Edges are counted including the accepting edge: non-zero divisor -> 34, zero divisor -> 2.
    function automatic int ref_lat(input logic [31:0] b);
        return (b == 32'd0) ? 2 : 34;
    endfunction

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic scramble, output logic [63:0] res, output int lat);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        if (scramble) begin
            signed_div_i = ~sgn;
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
        end
        while (!ready_o && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = result_o;
    endtask

    task automatic release_div();
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL reset: ready=%b result=%h, required ready=0 result=0", ready_o, result_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] a [6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5};
        logic [31:0] b [6] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd0};
        logic        s [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [63:0] want [6] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                                  {32'h1, 32'hFFFF_FFFD}, {32'h0, 32'h8000_0000},
                                  {32'h0, 32'hFFFF_FFFF}, 64'd0};
        logic [63:0] res;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_div(s[i], a[i], b[i], 1'b0, res, lat);
            checks++;
            if (lat !== ref_lat(b[i])) begin
                errors++;
                $display("FAIL directed%0d_latency: got %0d edges, required %0d", i, lat, ref_lat(b[i]));
            end
            checks++;
            if (res !== want[i]) begin
                errors++;
                $display("FAIL directed%0d_result: got %h, required %h", i, res, want[i]);
            end
            // Result must hold while start_i stays high.
            @(posedge clk); @(negedge clk);
            checks++;
            if (ready_o !== 1'b1 || result_o !== want[i]) begin
                errors++;
                $display("FAIL directed%0d_hold: ready=%b result=%h, required ready=1 result=%h", i, ready_o, result_o, want[i]);
            end
            release_div();
            checks++;
            if (ready_o !== 1'b0 || result_o !== 64'd0) begin
                errors++;
                $display("FAIL directed%0d_release: ready=%b result=%h, required 0/0", i, ready_o, result_o);
            end
        end
    endtask

    task automatic test_div_by_zero_unsigned();
        logic [63:0] res;
        int lat;
        run_div(1'b0, 32'd5, 32'd0, 1'b0, res, lat);
        checks++;
        if (lat !== 2 || res !== 64'd0) begin
            errors++;
            $display("FAIL divu_by_zero: lat=%0d result=%h, required lat=2 result=0", lat, res);
        end
        release_div();
    endtask

    task automatic test_random();
        logic [63:0] res, want;
        logic [31:0] a, b;
        logic        sgn;
        int lat;
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            case ($urandom % 5)
                0: b = $urandom_range(1, 15);
                1: b = -$urandom_range(1, 15);
                2: b = 32'd0;
                default: b = $urandom;
            endcase
            if (i % 6 == 0) a = a >> ($urandom % 32);
            want = ref_div(sgn, a, b);
            run_div(sgn, a, b, 1'b0, res, lat);
            checks++;
            if (lat !== ref_lat(b) || res !== want) begin
                errors++;
                $display("FAIL random%0d s=%b %h/%h: lat=%0d result=%h, required lat=%0d result=%h",
                         i, sgn, a, b, lat, res, ref_lat(b), want);
            end
            release_div();
        end
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int lat, seen;
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'd3; start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o !== 1'b0 || result_o !== 64'd0) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL annul_quiet: %0d cycles with ready/result set, required 0", seen);
        end
        run_div(1'b0, 32'd9, 32'd3, 1'b0, res, lat);
        checks++;
        if (lat !== 34 || res !== {32'd0, 32'd3}) begin
            errors++;
            $display("FAIL annul_followup: lat=%0d result=%h, required lat=34 result=%h", lat, res, {32'd0, 32'd3});
        end
        release_div();
    endtask

    task automatic test_rst_mid();
        logic [63:0] res;
        int lat;
        @(negedge clk);
        signed_div_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid: ready=%b result=%h, required 0/0", ready_o, result_o);
        end
        rst = 1'b0;
        run_div(1'b0, 32'd50, 32'd6, 1'b0, res, lat);
        checks++;
        if (lat !== 34 || res !== {32'd2, 32'd8}) begin
            errors++;
            $display("FAIL rst_followup: lat=%0d result=%h, required lat=34 result=%h", lat, res, {32'd2, 32'd8});
        end
        // Reset in the result-holding state clears the outputs too.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL rst_in_end: ready=%b result=%h, required 0/0", ready_o, result_o);
        end
        rst = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_operand_change();
        logic [63:0] res, want;
        int lat;
        want = ref_div(1'b1, 32'hFFFF_F000, 32'd37);
        run_div(1'b1, 32'hFFFF_F000, 32'd37, 1'b1, res, lat);
        checks++;
        if (lat !== 34 || res !== want) begin
            errors++;
            $display("FAIL operand_change: lat=%0d result=%h, required lat=34 result=%h", lat, res, want);
        end
        release_div();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero_unsigned();
        test_annul();
        test_rst_mid();
        test_operand_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
